imm_ext_pipe: RTL

- Parametrised, buffered successor to the combinational immediate extender. Sits between decode and the ID/EX register.
- Decodes the immediate from instruction bits [31:7] for XLEN 32 or 64. Adds CSR-zimm and shift-amount formats and an illegal-format flag.
- Results are held in a DEPTH-entry FIFO with valid/ready handshake on both sides, plus a synchronous flush for branch mispredicts.

---
 rtl/imm_ext_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a DEPTH-entry valid/ready result FIFO and synchronous flush.
// Optional IMM_EXT_ERR_CNT_EN adds a saturating illegal-format counter output err_count.
module imm_ext_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [24:0]      in_instr,
   input  logic [2:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_immext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
`ifdef IMM_EXT_ERR_CNT_EN
   ,
   output logic [15:0]      err_count
`endif
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      FMT_I   = 3'b000,
      FMT_S   = 3'b001,
      FMT_B   = 3'b010,
      FMT_J   = 3'b011,
      FMT_U   = 3'b100,
      FMT_Z   = 3'b101,
      FMT_SH  = 3'b110,
      FMT_BAD = 3'b111
   } imm_fmt_e;

   logic [XLEN-1:0]  dec_imm;
   logic             dec_err;
   logic [XLEN-1:0]  imm_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic             err_mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             push, pop;

   // in_instr holds instruction bits [31:7]; every index below is offset by 7
   always_comb begin
      dec_imm = '0;
      dec_err = 1'b0;
      case (imm_fmt_e'(in_immsrc))
         FMT_I:   dec_imm = XLEN'($signed(in_instr[24:13]));
         FMT_S:   dec_imm = XLEN'($signed({in_instr[24:18], in_instr[4:0]}));
         FMT_B:   dec_imm = XLEN'($signed({in_instr[24], in_instr[0], in_instr[23:18],
                                           in_instr[4:1], 1'b0}));
         FMT_J:   dec_imm = XLEN'($signed({in_instr[24], in_instr[12:5], in_instr[13],
                                           in_instr[23:14], 1'b0}));
         FMT_U:   dec_imm = XLEN'($signed({in_instr[24:5], 12'b0}));
         FMT_Z:   dec_imm = XLEN'(in_instr[12:8]);
         FMT_SH:  dec_imm = (XLEN == 64) ? XLEN'(in_instr[18:13]) : XLEN'(in_instr[17:13]);
         FMT_BAD: dec_err = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else if (flush) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (push) tail <= ptr_inc(tail);
         if (pop)  head <= ptr_inc(head);
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Storage is deliberately left out of reset; count gates every read
   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem[tail] <= dec_imm;
         tag_mem[tail] <= in_tag;
         err_mem[tail] <= dec_err;
      end
   end

   assign out_immext = out_valid ? imm_mem[head] : '0;
   assign out_tag    = out_valid ? tag_mem[head] : '0;
   assign out_err    = out_valid ? err_mem[head] : 1'b0;

`ifdef IMM_EXT_ERR_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_count <= '0;
      else if (push && dec_err && (err_count != '1))
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
